// File: rtl/pulse_timer_sched_if.sv
// Handshake bundle between requesters and the shared pulse timer.
// master = requester side, slave = timer side.
interface pulse_timer_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic                  cancel;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  modport master (
    output req, load_val, cancel,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, load_val, cancel,
    output grant, busy, count, done
  );
endinterface

// File: rtl/pulse_timer_sched.sv
// Round-robin shared down-counter: IDLE grant -> LOAD -> COUNT (L+1 cycles) -> DONE pulse.
// No backpressure; req is only sampled in IDLE, cancel aborts LOAD/COUNT without a done pulse.
module pulse_timer_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  pulse_timer_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [NREQ-1:0]  grant_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic [WIDTH-1:0] count_q;
  logic [IW-1:0]    last;
  logic [IW-1:0]    gidx;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] ld_val;

  // Walk offsets from far to near so the nearest requester after 'last' wins.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(last) + 1 + k) % NREQ;
      if (bus.req[IW'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign ld_val = bus.load_val[int'(gidx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      last    <= IW'(NREQ - 1);
      gidx    <= '0;
    end else begin
      done_q <= '0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= NREQ'(1) << pick_idx;
            gidx    <= pick_idx;
            busy_q  <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.cancel) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            last    <= gidx;
            state   <= S_IDLE;
          end else begin
            count_q <= ld_val;
            state   <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Cancel beats terminal count: the run ends silently.
          if (bus.cancel) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            last    <= gidx;
            state   <= S_IDLE;
          end else if (count_q == '0) begin
            done_q <= grant_q;
            state  <= S_DONE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        S_DONE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          last    <= gidx;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule

// File: tb/tb_pulse_timer_sched.sv
// Directed bench for pulse_timer_sched: edge 1 is the IDLE edge that samples req.
module tb_pulse_timer_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  pulse_timer_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  pulse_timer_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_loads(input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] l2, input logic [7:0] l3);
    bus.load_val = {l3, l2, l1, l0};
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'h0);
    check({tag, "_done"},  32'(bus.done),  32'h0);
    check({tag, "_busy"},  32'(bus.busy),  32'h0);
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b1;
    bus.req    = 4'b1111;
    bus.cancel = 1'b0;
    set_loads(8'd3, 8'd3, 8'd3, 8'd3);

    // Reset takes effect without any clock edge, and requests are ignored while held.
    #3;
    check_idle_outputs("rst_async");
    check("rst_async_count", 32'(bus.count), 32'h0);
    tick();
    tick();
    check_idle_outputs("rst_held");

    // Single requester 0, L = 15: done on edge 18, grant for 18 cycles.
    bus.req = 4'b0001;
    set_loads(8'd15, 8'd0, 8'd0, 8'd0);
    #2 rst = 1'b0;
    tick();
    check("t1_grant_e1", 32'(bus.grant), 32'h1);
    check("t1_busy_e1", 32'(bus.busy), 32'h1);
    bus.req = 4'b1110;
    tick();
    check("t1_count_e2", 32'(bus.count), 32'd15);
    for (int e = 3; e <= 17; e++) begin
      tick();
      check("t1_count", 32'(bus.count), 32'(17 - e));
      check("t1_nodone", 32'(bus.done), 32'h0);
    end
    check("t1_grant_e17", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("t1_done_e18", 32'(bus.done), 32'h1);
    check("t1_grant_e18", 32'(bus.grant), 32'h1);
    tick();
    check_idle_outputs("t1_e19");

    // Fresh reset, all four requesting, L = 2: strict rotation with an IDLE gap each time.
    rst = 1'b1;
    #2 rst = 1'b0;
    bus.req = 4'b1111;
    set_loads(8'd2, 8'd2, 8'd2, 8'd2);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t2_grant", 32'(bus.grant), 32'(4'b0001 << (n % 4)));
      tick();
      check("t2_count_load", 32'(bus.count), 32'd2);
      tick();
      tick();
      check("t2_count_zero", 32'(bus.count), 32'd0);
      check("t2_grant_hold", 32'(bus.grant), 32'(4'b0001 << (n % 4)));
      tick();
      check("t2_done", 32'(bus.done), 32'(4'b0001 << (n % 4)));
      tick();
      check_idle_outputs("t2_gap");
    end

    // Requester 2 with L = 0: LOAD, one COUNT cycle, DONE on edge 3.
    bus.req = 4'b0100;
    set_loads(8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("t3_grant_e1", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    tick();
    check("t3_nodone_e2", 32'(bus.done), 32'h0);
    tick();
    check("t3_done_e3", 32'(bus.done), 32'h4);
    tick();
    check_idle_outputs("t3_e4");

    // Requester 1, L = 10, cancel while count shows 4.
    bus.req = 4'b0010;
    set_loads(8'd0, 8'd10, 8'd0, 8'd0);
    tick();
    check("t4_grant_e1", 32'(bus.grant), 32'h2);
    bus.req = 4'b0000;
    tick();
    for (int e = 3; e <= 8; e++) tick();
    check("t4_count_e8", 32'(bus.count), 32'd4);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check_idle_outputs("t4_cancel");
    check("t4_count_hold", 32'(bus.count), 32'd4);
    tick();
    check("t4_count_idle", 32'(bus.count), 32'd4);
    check("t4_done_after", 32'(bus.done), 32'h0);
    bus.req = 4'b0110;
    tick();
    check("t4_next_grant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    check_idle_outputs("t4_drain");

    // Cancel coinciding with count == 0: cancel wins, no done.
    bus.req = 4'b0001;
    set_loads(8'd1, 8'd0, 8'd0, 8'd0);
    tick();
    check("t5_grant_e1", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    tick();
    tick();
    check("t5_count_zero", 32'(bus.count), 32'd0);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    check_idle_outputs("t5_cancel");
    tick();
    check("t5_done_late", 32'(bus.done), 32'h0);
    check("t5_busy_late", 32'(bus.busy), 32'h0);

    // Long run aborted by asynchronous reset at count = 100.
    bus.req = 4'b0001;
    set_loads(8'd200, 8'd0, 8'd0, 8'd0);
    tick();
    check("t6_grant_e1", 32'(bus.grant), 32'h1);
    bus.req = 4'b0000;
    tick();
    check("t6_count_e2", 32'(bus.count), 32'd200);
    repeat (100) tick();
    check("t6_count_e102", 32'(bus.count), 32'd100);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    check("t6_rst_count", 32'(bus.count), 32'h0);
    tick();
    bus.req = 4'b1001;
    #2 rst = 1'b0;
    tick();
    check("t6_regrant", 32'(bus.grant), 32'h1);
    check("t6_regrant_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b0000;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
